hazard_scoreboard: RTL and testbench

Parametrised hazard and bypass controller for the in-order MIPS pipeline. It sits beside the D stage and tracks every in-flight register write in a per-stage scoreboard. Each entry carries a Tnew countdown. From the scoreboard it derives the D-stage stall, the D-stage rs/rt forward-source selects, and multiply/divide busy interlocks. Stage depth, register-address width and MDU latencies are configurable.

---
 rtl/hazard_scoreboard_if.sv | 36 +++
 rtl/hazard_scoreboard.sv | 105 ++++++++++
 tb/tb_hazard_scoreboard.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// D-stage hazard/bypass bundle between the decode stage and hazard_scoreboard.
// master = decode side (drives D fields), slave = scoreboard (drives stall/selects).
interface hazard_scoreboard_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned TW     = 2,
  parameter int unsigned FW_W   = 2
);
  logic              d_valid;
  logic [REG_AW-1:0] d_rs;
  logic [REG_AW-1:0] d_rt;
  logic [TW-1:0]     d_rs_tuse;
  logic [TW-1:0]     d_rt_tuse;
  logic              d_we;
  logic [REG_AW-1:0] d_wa;
  logic [TW-1:0]     d_tnew;
  logic              d_md_start;
  logic              d_md_div;
  logic              d_md_use;
  logic              flush;
  logic              stall;
  logic [FW_W-1:0]   fw_rs_sel;
  logic [FW_W-1:0]   fw_rt_sel;
  logic              md_busy;

  modport master (
    output d_valid, d_rs, d_rt, d_rs_tuse, d_rt_tuse, d_we, d_wa, d_tnew,
           d_md_start, d_md_div, d_md_use, flush,
    input  stall, fw_rs_sel, fw_rt_sel, md_busy
  );

  modport slave (
    input  d_valid, d_rs, d_rt, d_rs_tuse, d_rt_tuse, d_we, d_wa, d_tnew,
           d_md_start, d_md_div, d_md_use, flush,
    output stall, fw_rs_sel, fw_rt_sel, md_busy
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tnew/Tuse scoreboard producing D-stage stall, forward selects and MDU interlock.
// Optional HAZARD_MDU_EN adds the multiply/divide busy counter and its hazard.
module hazard_scoreboard #(
  parameter int unsigned STAGES   = 3,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned TW       = 2,
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic            clk,
  input  logic            reset,
  hazard_scoreboard_if.slave hz
);
  localparam int unsigned FW_W = $clog2(STAGES + 1);

  typedef struct packed {
    logic              valid;
    logic              we;
    logic [REG_AW-1:0] wa;
    logic [TW-1:0]     tnew;
  } slot_t;

  typedef struct packed {
    logic            hit;
    logic [FW_W-1:0] k;
    logic [TW-1:0]   tnew;
  } match_t;

  slot_t  slot_q [1:STAGES];
  match_t rs_m;
  match_t rt_m;
  logic   rs_haz;
  logic   rt_haz;
  logic   md_haz;
  logic   stall_c;

  // Youngest (lowest-numbered) matching producer wins; $0 never matches.
  function automatic match_t find(input logic [REG_AW-1:0] r);
    match_t m;
    m = '0;
    for (int k = int'(STAGES); k >= 1; k--) begin
      if (slot_q[k].valid && slot_q[k].we && (slot_q[k].wa == r) && (r != '0)) begin
        m.hit  = 1'b1;
        m.k    = FW_W'(k);
        m.tnew = slot_q[k].tnew;
      end
    end
    return m;
  endfunction

  function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - TW'(1);
  endfunction

  // Slot shift register; a stalled or empty D injects a bubble into slot 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 1; k <= int'(STAGES); k++) slot_q[k] <= '0;
    end else if (hz.flush) begin
      for (int k = 1; k <= int'(STAGES); k++) slot_q[k] <= '0;
    end else begin
      slot_q[1] <= '{valid: hz.d_valid & ~stall_c, we: hz.d_we, wa: hz.d_wa, tnew: hz.d_tnew};
      for (int k = 2; k <= int'(STAGES); k++) begin
        slot_q[k] <= '{valid: slot_q[k-1].valid, we: slot_q[k-1].we,
                       wa: slot_q[k-1].wa, tnew: dec_sat(slot_q[k-1].tnew)};
      end
    end
  end

  always_comb begin
    rs_m   = find(hz.d_rs);
    rt_m   = find(hz.d_rt);
    rs_haz = rs_m.hit && (rs_m.tnew > hz.d_rs_tuse);
    rt_haz = rt_m.hit && (rt_m.tnew > hz.d_rt_tuse);
  end

  assign stall_c      = hz.d_valid & (rs_haz | rt_haz | md_haz);
  assign hz.stall     = stall_c;
  assign hz.fw_rs_sel = (hz.d_valid && rs_m.hit && (rs_m.tnew == '0)) ? rs_m.k : '0;
  assign hz.fw_rt_sel = (hz.d_valid && rt_m.hit && (rt_m.tnew == '0)) ? rt_m.k : '0;

`ifdef HAZARD_MDU_EN
  localparam int unsigned MD_MAX = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
  localparam int unsigned CW     = $clog2(MD_MAX + 1);

  logic [CW-1:0] md_cnt;

  // A start only counts when it actually leaves D; a running count ignores flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_cnt <= '0;
    end else if (hz.d_valid && hz.d_md_start && !stall_c && !hz.flush) begin
      md_cnt <= hz.d_md_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - CW'(1);
    end
  end

  assign hz.md_busy = (md_cnt != '0);
  assign md_haz     = hz.d_valid & (hz.d_md_use | hz.d_md_start) & hz.md_busy;
`else
  assign hz.md_busy = 1'b0;
  assign md_haz     = 1'b0;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard (STAGES = 3); MDU checks follow HAZARD_MDU_EN.
module tb_hazard_scoreboard;
  localparam int unsigned STAGES = 3;

  logic clk;
  logic reset;

  hazard_scoreboard_if #(.REG_AW(5), .TW(2), .FW_W(2)) hz ();

  hazard_scoreboard #(.STAGES(STAGES), .REG_AW(5), .TW(2), .MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] mask;  // [0] stall [1] rs_sel [2] rt_sel [3] md_busy
    logic       st;
    logic [1:0] rs;
    logic [1:0] rt;
    logic       busy;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic chk(input string n, input string f, input logic [3:0] act, input logic [3:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s.%s: got %0d expected %0d at %0t", n, f, act, req, $time);
    end
  endtask

  // Monitor: compare whatever expectations are pending, mid-cycle.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      e = q.pop_front();
      if (e.mask[0]) chk(e.name, "stall",     4'(hz.stall),     4'(e.st));
      if (e.mask[1]) chk(e.name, "fw_rs_sel", 4'(hz.fw_rs_sel), 4'(e.rs));
      if (e.mask[2]) chk(e.name, "fw_rt_sel", 4'(hz.fw_rt_sel), 4'(e.rt));
      if (e.mask[3]) chk(e.name, "md_busy",   4'(hz.md_busy),   4'(e.busy));
    end
  end

  task automatic want(input string n, input logic st, input logic [1:0] rs,
                      input logic [1:0] rt, input logic busy);
    exp_t x;
    x.name = n; x.mask = 4'hF; x.st = st; x.rs = rs; x.rt = rt; x.busy = busy;
    q.push_back(x);
  endtask

  task automatic want_stall(input string n, input logic st);
    exp_t x;
    x.name = n; x.mask = 4'h1; x.st = st; x.rs = '0; x.rt = '0; x.busy = 1'b0;
    q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hz.d_valid = 1'b0; hz.d_we = 1'b0; hz.d_wa = '0; hz.d_tnew = '0;
    hz.d_rs = '0; hz.d_rt = '0; hz.d_rs_tuse = '0; hz.d_rt_tuse = '0;
    hz.d_md_start = 1'b0; hz.d_md_div = 1'b0; hz.d_md_use = 1'b0;
  endtask

  task automatic issue(input logic we, input logic [4:0] wa, input logic [1:0] tnew,
                       input logic [4:0] rs, input logic [1:0] rs_tuse,
                       input logic [4:0] rt, input logic [1:0] rt_tuse);
    idle();
    hz.d_valid = 1'b1; hz.d_we = we; hz.d_wa = wa; hz.d_tnew = tnew;
    hz.d_rs = rs; hz.d_rs_tuse = rs_tuse; hz.d_rt = rt; hz.d_rt_tuse = rt_tuse;
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < int'(STAGES); i++) begin
      want("idle", 1'b0, 2'd0, 2'd0, 1'b0);
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; hz.flush = 1'b0; idle();
    tick();
    want("reset", 1'b0, 2'd0, 2'd0, 1'b0);
    tick();
    reset = 1'b0;

    // lw $1 (tnew 2) then addu rs=$1 (tuse 1)
    issue(1'b1, 5'd1, 2'd2, 5'd2, 2'd1, 5'd0, 2'd1);
    want("lw_a", 1'b0, 2'd0, 2'd0, 1'b0);
    tick();
    issue(1'b1, 5'd4, 2'd1, 5'd1, 2'd1, 5'd5, 2'd1);
    want("addu_stall", 1'b1, 2'd0, 2'd0, 1'b0);
    tick();
    want_stall("addu_go", 1'b0);
    tick();
    drain();

    // lw $1 then beq rs=$1 (tuse 0): two stalls, then bypass from slot 3
    issue(1'b1, 5'd1, 2'd2, 5'd2, 2'd1, 5'd0, 2'd1);
    want("lw_b", 1'b0, 2'd0, 2'd0, 1'b0);
    tick();
    issue(1'b0, 5'd0, 2'd0, 5'd1, 2'd0, 5'd6, 2'd0);
    want("beq_st1", 1'b1, 2'd0, 2'd0, 1'b0);
    tick();
    want("beq_st2", 1'b1, 2'd0, 2'd0, 1'b0);
    tick();
    want("beq_fw3", 1'b0, 2'd3, 2'd0, 1'b0);
    tick();
    drain();

    // ori $3 then addu $3 (both tnew 0): youngest producer wins on rt
    issue(1'b1, 5'd3, 2'd0, 5'd0, 2'd1, 5'd0, 2'd1);
    want("ori3", 1'b0, 2'd0, 2'd0, 1'b0);
    tick();
    issue(1'b1, 5'd3, 2'd0, 5'd7, 2'd1, 5'd0, 2'd1);
    want("addu3", 1'b0, 2'd0, 2'd0, 1'b0);
    tick();
    issue(1'b0, 5'd0, 2'd0, 5'd8, 2'd1, 5'd3, 2'd1);
    want("rt_young", 1'b0, 2'd0, 2'd1, 1'b0);
    tick();
    issue(1'b0, 5'd0, 2'd0, 5'd8, 2'd1, 5'd3, 2'd1);
    want("rt_slot2", 1'b0, 2'd0, 2'd2, 1'b0);
    tick();
    drain();

    // $0 is never a hazard
    issue(1'b1, 5'd0, 2'd2, 5'd2, 2'd1, 5'd0, 2'd1);
    want("w_r0", 1'b0, 2'd0, 2'd0, 1'b0);
    tick();
    issue(1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0);
    want("rd_r0", 1'b0, 2'd0, 2'd0, 1'b0);
    tick();
    drain();

    // mult then mflo
    issue(1'b0, 5'd0, 2'd0, 5'd10, 2'd1, 5'd11, 2'd1);
    hz.d_md_start = 1'b1;
    want("mult", 1'b0, 2'd0, 2'd0, 1'b0);
    tick();
    issue(1'b1, 5'd9, 2'd0, 5'd0, 2'd1, 5'd0, 2'd1);
    hz.d_md_use = 1'b1;
`ifdef HAZARD_MDU_EN
    for (int i = 0; i < 5; i++) begin
      want("mflo_mult_st", 1'b1, 2'd0, 2'd0, 1'b1);
      tick();
    end
`endif
    want("mflo_mult_go", 1'b0, 2'd0, 2'd0, 1'b0);
    tick();
    drain();

    // div then mflo
    issue(1'b0, 5'd0, 2'd0, 5'd10, 2'd1, 5'd11, 2'd1);
    hz.d_md_start = 1'b1; hz.d_md_div = 1'b1;
    want("div", 1'b0, 2'd0, 2'd0, 1'b0);
    tick();
    issue(1'b1, 5'd9, 2'd0, 5'd0, 2'd1, 5'd0, 2'd1);
    hz.d_md_use = 1'b1;
`ifdef HAZARD_MDU_EN
    for (int i = 0; i < 10; i++) begin
      want("mflo_div_st", 1'b1, 2'd0, 2'd0, 1'b1);
      tick();
    end
`endif
    want("mflo_div_go", 1'b0, 2'd0, 2'd0, 1'b0);
    tick();
    drain();

    // flush while beq is stalled behind lw
    issue(1'b1, 5'd1, 2'd2, 5'd2, 2'd1, 5'd0, 2'd1);
    want("fl_lw", 1'b0, 2'd0, 2'd0, 1'b0);
    tick();
    issue(1'b0, 5'd0, 2'd0, 5'd1, 2'd0, 5'd0, 2'd0);
    want("fl_pre", 1'b1, 2'd0, 2'd0, 1'b0);
    hz.flush = 1'b1;
    tick();
    hz.flush = 1'b0;
    want("fl_post", 1'b0, 2'd0, 2'd0, 1'b0);
    tick();
    drain();

    // flush together with an MDU start discards the start
    issue(1'b0, 5'd0, 2'd0, 5'd10, 2'd1, 5'd11, 2'd1);
    hz.d_md_start = 1'b1; hz.flush = 1'b1;
    want("fl_start", 1'b0, 2'd0, 2'd0, 1'b0);
    tick();
    hz.flush = 1'b0; idle();
    want("fl_start_after", 1'b0, 2'd0, 2'd0, 1'b0);
    tick();

    // reset during a divide with mflo stalled
    issue(1'b0, 5'd0, 2'd0, 5'd10, 2'd1, 5'd11, 2'd1);
    hz.d_md_start = 1'b1; hz.d_md_div = 1'b1;
    want("div2", 1'b0, 2'd0, 2'd0, 1'b0);
    tick();
    issue(1'b1, 5'd9, 2'd0, 5'd0, 2'd1, 5'd0, 2'd1);
    hz.d_md_use = 1'b1;
`ifdef HAZARD_MDU_EN
    want("div2_stall", 1'b1, 2'd0, 2'd0, 1'b1);
`else
    want("div2_stall", 1'b0, 2'd0, 2'd0, 1'b0);
`endif
    tick();
    reset = 1'b1;
    want("rst_mid", 1'b0, 2'd0, 2'd0, 1'b0);
    tick();
    reset = 1'b0;
    want("post_rst", 1'b0, 2'd0, 2'd0, 1'b0);
    tick();
    idle();
    tick();
    tick();

    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
